// File: rtl/apb_master_bridge_pkg.sv
// Shared types and helpers for the APB requester bridge.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic {
    P_WRITE = 1'b1,
    P_READ  = 1'b0
  } apb_op_e;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned TIMER_OUT_DEF = 10;
  localparam int unsigned STRB_W        = DATA_W_DEF / 8;

  // Byte-strobe width for a given data bus width.
  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Counter width able to hold 0..timer_out, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned timer_out);
    return (timer_out < 2) ? 1 : $clog2(timer_out + 1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command port plus APB bus bundle; master = bridge side, slave = the far side.
interface apb_master_bridge_if
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SW = strb_w(DATA_WIDTH);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [SW-1:0]         cmd_strb;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [SW-1:0]         PSTRB;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// Saturating wait-state counter; expire_c_o flags the cycle that hits TIMER_OUT.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMER_OUT = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_c_o
);
  localparam int unsigned  CNT_W    = cnt_w(TIMER_OUT);
  localparam bit           TIMER_EN = (TIMER_OUT != 0);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMER_OUT == 0) ? 0 : TIMER_OUT - 1);
  localparam logic [CNT_W-1:0] MAX  = '1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The increment that would reach TIMER_OUT is the abort cycle.
  assign expire_c_o = TIMER_EN && en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3/APB4 requester: one valid/ready command in, one SETUP/ACCESS transfer, one response pulse out.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned TIMER_OUT  = TIMER_OUT_DEF
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_bridge_if.master bus
);
  localparam int unsigned SW = strb_w(DATA_WIDTH);

  apb_state_e            state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [SW-1:0]         pstrb_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  logic                  cmd_ready_c;
  logic                  accept_c;
  logic                  is_write_c;
  logic [DATA_WIDTH-1:0] ld_wdata_c;
  logic [SW-1:0]         ld_strb_c;
  logic                  timer_clear_c;
  logic                  timer_en_c;
  logic                  expire_c;

  assign cmd_ready_c = (state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY);
  assign accept_c    = bus.cmd_valid && cmd_ready_c;

  // Reads drive zero write data and strobes onto the bus.
  always_comb begin
    is_write_c = (apb_op_e'(bus.cmd_write) == P_WRITE);
    ld_wdata_c = '0;
    ld_strb_c  = '0;
    if (is_write_c) begin
      ld_wdata_c = bus.cmd_wdata;
      ld_strb_c  = bus.cmd_strb;
    end
  end

  assign timer_clear_c = (state_q == SETUP);
  assign timer_en_c    = (state_q == ACCESS) && !bus.PREADY;

  apb_wait_timer #(
    .TIMER_OUT (TIMER_OUT)
  ) u_wait_timer (
    .clk_i      (PCLK),
    .rst_i      (PRESET),
    .clear_i    (timer_clear_c),
    .en_i       (timer_en_c),
    .expire_c_o (expire_c)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      // A new command may load from IDLE or from a completing ACCESS.
      if (accept_c) begin
        state_q   <= SETUP;
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        pwrite_q  <= is_write_c;
        paddr_q   <= bus.cmd_addr;
        pwdata_q  <= ld_wdata_c;
        pstrb_q   <= ld_strb_c;
      end
      case (state_q)
        IDLE: begin
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
            rsp_err_q     <= bus.PSLVERR;
            rsp_timeout_q <= 1'b0;
            if (!accept_c) begin
              state_q   <= IDLE;
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
            end
          end else if (expire_c) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: the bench plays both the command source and the APB slave.
module tb_apb_master_bridge;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMER_OUT  (10)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_strb  = strb;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // Single write, zero wait
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    tick(); bus.cmd_valid = 1'b0;
    chk("w1_setup_psel", bus.PSEL, 1);
    chk("w1_setup_penable", bus.PENABLE, 0);
    chk("w1_paddr", bus.PADDR, 32'h10);
    chk("w1_pwdata", bus.PWDATA, 32'hDEADBEEF);
    chk("w1_pstrb", bus.PSTRB, 4'hF);
    chk("w1_pwrite", bus.PWRITE, 1);
    chk("w1_setup_ready", bus.cmd_ready, 0);
    tick();
    chk("w1_access_penable", bus.PENABLE, 1);
    chk("w1_access_ready", bus.cmd_ready, 1);
    tick();
    chk("w1_rsp_valid", bus.rsp_valid, 1);
    chk("w1_rsp_err", bus.rsp_err, 0);
    chk("w1_rsp_rdata", bus.rsp_rdata, 0);
    chk("w1_psel_drop", bus.PSEL, 0);
    tick();
    chk("w1_rsp_pulse", bus.rsp_valid, 0);
    chk("w1_paddr_hold", bus.PADDR, 32'h10);

    // Read with two wait states
    send(1'b0, 32'h20, 32'hAAAA5555, 4'hF);
    tick(); bus.cmd_valid = 1'b0; bus.PREADY = 1'b0;
    chk("r1_pwdata_zero", bus.PWDATA, 0);
    chk("r1_pstrb_zero", bus.PSTRB, 0);
    chk("r1_pwrite", bus.PWRITE, 0);
    tick();
    chk("r1_wait1_penable", bus.PENABLE, 1);
    chk("r1_wait1_ready", bus.cmd_ready, 0);
    tick();
    chk("r1_wait2_penable", bus.PENABLE, 1);
    chk("r1_wait2_rsp", bus.rsp_valid, 0);
    tick();
    chk("r1_acc3_penable", bus.PENABLE, 1);
    bus.PREADY = 1'b1; bus.PRDATA = 32'h12345678;
    tick(); bus.PRDATA = '0;
    chk("r1_rsp_valid", bus.rsp_valid, 1);
    chk("r1_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    chk("r1_rsp_err", bus.rsp_err, 0);
    chk("r1_psel_drop", bus.PSEL, 0);
    tick();

    // Three back-to-back writes
    send(1'b1, 32'h0, 32'h11111111, 4'h3);
    tick();
    chk("b2b_0_psel", bus.PSEL, 1);
    chk("b2b_0_pwdata", bus.PWDATA, 32'h11111111);
    chk("b2b_0_pstrb", bus.PSTRB, 4'h3);
    tick();
    chk("b2b_0_penable", bus.PENABLE, 1);
    send(1'b1, 32'h4, 32'h22222222, 4'hC);
    tick();
    chk("b2b_rsp0", bus.rsp_valid, 1);
    chk("b2b_1_psel", bus.PSEL, 1);
    chk("b2b_1_penable_low", bus.PENABLE, 0);
    chk("b2b_1_paddr", bus.PADDR, 32'h4);
    tick();
    chk("b2b_1_penable", bus.PENABLE, 1);
    chk("b2b_1_psel_held", bus.PSEL, 1);
    send(1'b1, 32'h8, 32'h33333333, 4'hF);
    tick(); bus.cmd_valid = 1'b0;
    chk("b2b_rsp1", bus.rsp_valid, 1);
    chk("b2b_2_psel", bus.PSEL, 1);
    chk("b2b_2_paddr", bus.PADDR, 32'h8);
    chk("b2b_2_pwdata", bus.PWDATA, 32'h33333333);
    tick();
    chk("b2b_2_rsp_gap", bus.rsp_valid, 0);
    tick();
    chk("b2b_rsp2", bus.rsp_valid, 1);
    chk("b2b_end_psel", bus.PSEL, 0);
    tick();

    // PREADY stuck low: abort after ten wait cycles
    bus.PREADY = 1'b0; bus.PRDATA = 32'hFFFF0000;
    send(1'b0, 32'h30, 32'h0, 4'h0);
    tick(); bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("to_wait%0d_penable", i), bus.PENABLE, 1);
      chk($sformatf("to_wait%0d_rsp", i), bus.rsp_valid, 0);
    end
    tick();
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_err", bus.rsp_err, 1);
    chk("to_rsp_timeout", bus.rsp_timeout, 1);
    chk("to_rsp_rdata", bus.rsp_rdata, 0);
    chk("to_psel", bus.PSEL, 0);
    chk("to_penable", bus.PENABLE, 0);
    bus.PREADY = 1'b1; bus.PRDATA = '0;
    chk("to_ready_after", bus.cmd_ready, 1);
    send(1'b1, 32'h40, 32'h0BADF00D, 4'h1);
    tick(); bus.cmd_valid = 1'b0;
    chk("to_next_psel", bus.PSEL, 1);
    chk("to_next_paddr", bus.PADDR, 32'h40);
    tick(); tick();
    chk("to_next_rsp", bus.rsp_valid, 1);
    chk("to_next_timeout_clr", bus.rsp_timeout, 0);
    chk("to_next_err_clr", bus.rsp_err, 0);
    tick();

    // Read completing with PSLVERR
    bus.PSLVERR = 1'b1; bus.PRDATA = 32'hCAFEF00D;
    send(1'b0, 32'h50, 32'h0, 4'h0);
    tick(); bus.cmd_valid = 1'b0;
    tick();
    tick(); bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    chk("err_rsp_valid", bus.rsp_valid, 1);
    chk("err_rsp_err", bus.rsp_err, 1);
    chk("err_rsp_timeout", bus.rsp_timeout, 0);
    chk("err_rsp_rdata", bus.rsp_rdata, 0);
    tick();
    chk("err_hold_valid", bus.rsp_valid, 0);
    chk("err_hold_err", bus.rsp_err, 1);

    // Reset during ACCESS after one wait
    bus.PREADY = 1'b0;
    send(1'b1, 32'h60, 32'h55AA55AA, 4'hF);
    tick(); bus.cmd_valid = 1'b0;
    tick();
    chk("mr_access", bus.PENABLE, 1);
    rst = 1'b1;
    tick();
    chk("mr_psel", bus.PSEL, 0);
    chk("mr_penable", bus.PENABLE, 0);
    chk("mr_paddr", bus.PADDR, 0);
    chk("mr_pwdata", bus.PWDATA, 0);
    chk("mr_pstrb", bus.PSTRB, 0);
    chk("mr_pwrite", bus.PWRITE, 0);
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_rsp_err", bus.rsp_err, 0);
    rst = 1'b0; bus.PREADY = 1'b1;
    chk("mr_cmd_ready", bus.cmd_ready, 1);
    tick();
    chk("mr_no_rsp", bus.rsp_valid, 0);
    chk("mr_idle_psel", bus.PSEL, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB3/APB4 requester that drives the APB_slave under test from the other end of the bus. Accepts single read/write commands over a valid/ready command port and sequences SETUP/ACCESS phases. Supports back-to-back transfers, unbounded or bounded wait states via a PREADY timeout, and PSLVERR capture. Returns one response pulse per command; used as the RTL bus master in slave integration benches and as a reusable bridge.

Parameters:
ADDR_WIDTH, 32, PADDR/cmd_addr width
DATA_WIDTH, 32, PWDATA/PRDATA width (8, 16 or 32)
TIMER_OUT, 10, max consecutive ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK  in  1  bus clock; all logic on rising edge
PRESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data (0 for writes, errors, timeouts)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  DATA_WIDTH/8  APB strobes
PREADY  in  1  slave ready
PRDATA  in  DATA_WIDTH  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset (PRESET=1 at edge): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_* all 0; timeout counter 0. Reset mid-transfer abandons it; no response issued.
- FSM states: IDLE, SETUP, ACCESS.
- cmd_ready = (state==IDLE) | (state==ACCESS & PREADY); combinational, never depends on cmd_valid.
- IDLE: on accept -> SETUP; register PADDR, PWRITE, PWDATA, PSTRB; PSEL=1, PENABLE=0.
- SETUP: always -> ACCESS next cycle; PENABLE=1; counter cleared.
- ACCESS, PREADY=1: transfer completes. Next cycle: rsp_valid=1, rsp_rdata=PRDATA on reads else 0, rsp_err=PSLVERR, rsp_timeout=0. With a new command accepted in the same cycle -> SETUP (PSEL stays 1, PENABLE=0, new address/controls). Without one -> IDLE (PSEL=0, PENABLE=0).
- ACCESS, PREADY=0: increment counter. When TIMER_OUT!=0 and counter reaches TIMER_OUT, abort: -> IDLE, PSEL/PENABLE=0 next cycle, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Counter saturates and never wraps.
- Latency with zero wait: accept at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> rsp_valid in cycle 3. Each wait state adds 1 cycle.
- Reads drive PWDATA=0 and PSTRB=0. PADDR, PWRITE, PWDATA and PSTRB hold stable from SETUP through completion, and stay at last values while IDLE. PSEL stays 1 throughout SETUP and ACCESS.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata, rsp_err and rsp_timeout hold their last values when rsp_valid=0.
- PRDATA and PSLVERR are sampled only in ACCESS with PREADY=1, and ignored otherwise.
- Exactly one response per accepted command, in order.

Decomposition:
- Shared package apb_master_pkg: apb_state_e {IDLE, SETUP, ACCESS}; operation enum {P_WRITE, P_READ} matching TB naming; STRB_W derived constant.
- One sub-module, apb_wait_timer: loadable clear, enable-count, saturating counter with terminal flag against TIMER_OUT; instantiated once in the top.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY tied 1 -> PSEL cycle 1, PENABLE cycle 2, rsp_valid cycle 3, rsp_err=0.
- Read 0x20, slave inserts 2 wait states, PRDATA=0x12345678 -> ACCESS held 3 cycles, rsp_rdata=0x12345678, PWDATA=0, PSTRB=0.
- Three back-to-back writes 0x0/0x4/0x8, cmd_valid held high -> PSEL never drops, PENABLE low 1 cycle between transfers, three rsp_valid pulses.
- PREADY held 0, TIMER_OUT=10 -> abort after 10 wait cycles, rsp_err=1, rsp_timeout=1, PSEL=0 next cycle, next command accepted.
- Read with PSLVERR=1 on completion -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- PRESET asserted in ACCESS after 1 wait -> all outputs 0 next cycle, no rsp_valid, cmd_ready=1 after release.
